// File: rtl/control_stage_if.sv
// FSM/CSR-facing bundle of the CONTROL stage: stage handshake, PC inputs and trap state outputs.
// The sequencer side drives through master; the stage itself sits on slave.
interface control_stage_if #(
    parameter int XLEN = 32
);
    logic            active;
    logic [1:0]      control_op;
    logic [2:0]      fault_num;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] mtvec;
    logic            mie;
    logic            done;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic            trap_entry;

    modport master (
        output active, control_op, fault_num, next_pc, mtvec, mie,
        input  done, pc, mepc, mcause, trap_entry
    );

    modport slave (
        input  active, control_op, fault_num, next_pc, mtvec, mie,
        output done, pc, mepc, mcause, trap_entry
    );
endinterface

// File: rtl/control_stage.sv
// CONTROL stage: owns the architectural PC, advances it or redirects it to the trap vector, records mepc/mcause.
// Latency: active rise to done is 2 cycles for normal, 4 for trap/interrupt; done is held until active drops.
module control_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic reset_n,
    control_stage_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_SAVE,
        S_VECTOR,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_TRAP    = 2'b00;
    localparam logic [1:0] OP_EXT_INT = 2'b01;
    localparam logic [1:0] OP_SW_INT  = 2'b10;
    localparam logic [1:0] OP_NORMAL  = 2'b11;

    state_t          state;
    logic [1:0]      op_q;
    logic [2:0]      fn_q;
    logic            mie_q;
    logic            first;
    logic            done_q;
    logic            trap_entry_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;

    // An interrupt with the global enable clear retires like a normal instruction.
    logic take_normal;
    assign take_normal = (op_q == OP_NORMAL) ||
                         ((op_q == OP_EXT_INT || op_q == OP_SW_INT) && !mie_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            op_q         <= OP_NORMAL;
            fn_q         <= '0;
            mie_q        <= 1'b0;
            first        <= 1'b1;
            done_q       <= 1'b0;
            trap_entry_q <= 1'b0;
            pc_q         <= RESET_PC;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            trap_entry_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.active) begin
                        op_q  <= bus.control_op;
                        fn_q  <= bus.fault_num;
                        mie_q <= bus.mie;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (take_normal) begin
                        // Until something has retired, pc already names the instruction to fetch.
                        if (!first) begin
                            pc_q <= bus.next_pc;
                        end
                        first  <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_SAVE;
                    end
                end
                S_SAVE: begin
                    if (op_q == OP_TRAP) begin
                        mepc_q   <= pc_q;
                        mcause_q <= {{(XLEN-4){1'b0}}, 1'b0, fn_q};
                    end else begin
                        mepc_q   <= first ? pc_q : bus.next_pc;
                        mcause_q <= {1'b1, {(XLEN-5){1'b0}},
                                     (op_q == OP_EXT_INT) ? 4'd11 : 4'd3};
                    end
                    trap_entry_q <= 1'b1;
                    state        <= S_VECTOR;
                end
                S_VECTOR: begin
                    pc_q   <= bus.mtvec & {{(XLEN-2){1'b1}}, 2'b00};
                    first  <= 1'b0;
                    done_q <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    if (!bus.active) begin
                        done_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.done       = done_q;
    assign bus.trap_entry = trap_entry_q;
    assign bus.pc         = pc_q;
    assign bus.mepc       = mepc_q;
    assign bus.mcause     = mcause_q;
endmodule

// File: tb/tb_control_stage.sv
// Randomized bench for control_stage against a transaction-level model of PC/mepc/mcause and done/trap_entry timing.
module tb_control_stage;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    control_stage_if #(.XLEN(32)) bus ();

    control_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state as the sequencer sees it after each completed stage.
    logic [31:0] m_pc;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    bit          m_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_mepc   = 32'h0;
        m_mcause = 32'h0;
        m_first  = 1'b1;
    endtask

    task automatic run_txn(input logic [1:0] op, input logic [2:0] fn, input logic [31:0] npc,
                           input logic [31:0] tvec, input logic mie_v, input int hold,
                           input bit early_drop);
        bit   trap;
        int   lat;
        int   seen_done;
        int   te_cnt;
        int   te_cyc;

        trap = (op == 2'b00) || ((op == 2'b01 || op == 2'b10) && mie_v);
        if (!trap) begin
            if (!m_first) m_pc = npc;
        end else if (op == 2'b00) begin
            m_mepc   = m_pc;
            m_mcause = {29'h0, fn};
            m_pc     = {tvec[31:2], 2'b00};
        end else begin
            m_mepc   = m_first ? m_pc : npc;
            m_mcause = 32'h8000_0000 + ((op == 2'b01) ? 32'd11 : 32'd3);
            m_pc     = {tvec[31:2], 2'b00};
        end
        m_first = 1'b0;
        lat     = trap ? 4 : 2;

        @(negedge clk);
        bus.active     = 1'b1;
        bus.control_op = op;
        bus.fault_num  = fn;
        bus.next_pc    = npc;
        bus.mtvec      = tvec;
        bus.mie        = mie_v;

        seen_done = 0;
        te_cnt    = 0;
        te_cyc    = 0;
        for (int c = 1; c <= 12 && seen_done == 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.trap_entry) begin
                te_cnt++;
                te_cyc = c;
            end
            if (bus.done) seen_done = c;
            // Inputs latched at entry must not matter afterwards.
            bus.control_op = 2'($urandom);
            bus.fault_num  = 3'($urandom);
            bus.mie        = 1'($urandom);
            if (early_drop) bus.active = 1'b0;
        end
        check("done_latency", seen_done, lat);
        check("trap_entry_count", te_cnt, trap ? 1 : 0);
        if (trap) check("trap_entry_cycle", te_cyc, 3);
        check("pc", bus.pc, m_pc);
        check("mepc", bus.mepc, m_mepc);
        check("mcause", bus.mcause, m_mcause);

        if (!early_drop) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check("done_held", bus.done, 1);
                check("pc_held", bus.pc, m_pc);
                check("mepc_held", bus.mepc, m_mepc);
                check("mcause_held", bus.mcause, m_mcause);
                check("trap_entry_held", bus.trap_entry, 0);
            end
            bus.active = 1'b0;
        end
        @(posedge clk);
        #1;
        check("done_drop", bus.done, 0);
        check("pc_after", bus.pc, m_pc);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n        = 1'b0;
        bus.active     = 1'b0;
        bus.control_op = 2'b11;
        bus.fault_num  = 3'd0;
        bus.next_pc    = 32'h0;
        bus.mtvec      = 32'h0;
        bus.mie        = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", bus.done, 0);
        check("rst_trap_entry", bus.trap_entry, 0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_mepc", bus.mepc, 32'h0);
        check("rst_mcause", bus.mcause, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // First retirement keeps the reset PC, then sequential flow.
        run_txn(2'b11, 3'd0, 32'h4, 32'h0, 1'b0, 0, 1'b0);
        run_txn(2'b11, 3'd0, 32'h8, 32'h0, 1'b0, 0, 1'b0);
        run_txn(2'b11, 3'd0, 32'h100, 32'h0, 1'b0, 0, 1'b0);
        // Synchronous trap with misaligned vector.
        run_txn(2'b00, 3'd2, 32'h104, 32'h203, 1'b0, 0, 1'b0);
        // Enabled interrupts, external then software.
        run_txn(2'b01, 3'd5, 32'h44, 32'h300, 1'b1, 1, 1'b0);
        run_txn(2'b10, 3'd1, 32'h48, 32'h401, 1'b1, 0, 1'b0);
        // Masked interrupt retires normally.
        run_txn(2'b01, 3'd7, 32'h44, 32'h500, 1'b0, 0, 1'b0);
        // Long hold in DONE.
        run_txn(2'b00, 3'd6, 32'h60, 32'h600, 1'b1, 10, 1'b0);
        // active withdrawn early: sequence completes, then returns to IDLE.
        run_txn(2'b11, 3'd0, 32'h70, 32'h0, 1'b0, 0, 1'b1);
        run_txn(2'b10, 3'd0, 32'h74, 32'h700, 1'b1, 0, 1'b1);

        // Asynchronous reset while in SAVE.
        check("pre_reset_pc_nonzero", (bus.pc != 32'h0) ? 1 : 0, 1);
        @(negedge clk);
        bus.active     = 1'b1;
        bus.control_op = 2'b00;
        bus.fault_num  = 3'd5;
        bus.next_pc    = 32'h80;
        bus.mtvec      = 32'h900;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("arst_done", bus.done, 0);
        check("arst_trap_entry", bus.trap_entry, 0);
        check("arst_pc", bus.pc, 32'h0);
        check("arst_mepc", bus.mepc, 32'h0);
        check("arst_mcause", bus.mcause, 32'h0);
        bus.active = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(2'b11, 3'd0, 32'h30, 32'h0, 1'b0, 0, 1'b0);
        run_txn(2'b00, 3'd4, 32'h34, 32'hA0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            run_txn(2'($urandom), 3'($urandom), $urandom, $urandom, 1'($urandom),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 40) == 0) begin
                @(negedge clk);
                reset_n = 1'b0;
                model_reset();
                @(negedge clk);
                reset_n = 1'b1;
                check("rnd_rst_pc", bus.pc, 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
